// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants and elaboration helpers for the pipelined carry-lookahead
// adder (pipelined_cla_adder) and its per-stage lookahead group (cla_group).
//   DEFAULT_WIDTH / DEFAULT_GROUP : default operand width and group size
//   calc_nstage()                 : pipeline depth = number of groups
//   params_ok()                   : WIDTH must be a non-zero multiple of GROUP
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_GROUP = 4;

    function automatic int calc_nstage(input int width, input int group);
        return width / group;
    endfunction

    function automatic bit params_ok(input int width, input int group);
        return (group > 0) && (width >= group) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder_if
// Operand/result handshake bundle for pipelined_cla_adder.
//   in_valid/in_ready   : operand handshake (source -> adder)
//   A, B, cin           : operands and carry-in
//   out_valid/out_ready : result handshake (adder -> sink)
//   S, cout             : sum and carry-out
//   ovf                 : signed overflow, only when CLA_OVERFLOW_FLAG_EN is set
// Modports: master = source/sink side, slave = adder side.
// -----------------------------------------------------------------------------
interface pipelined_cla_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
`ifdef CLA_OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, S, cout
`ifdef CLA_OVERFLOW_FLAG_EN
        , ovf
`endif
    );

    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, S, cout
`ifdef CLA_OVERFLOW_FLAG_EN
        , ovf
`endif
    );

endinterface

// File: rtl/cla_group.sv
// -----------------------------------------------------------------------------
// cla_group
// Combinational GROUP-bit carry-lookahead block.
//   a, b   : group operand bits
//   ci     : carry into the group
//   s      : group sum bits
//   co     : carry out of the group
//   p_grp  : group propagate (all bits propagate)
//   g_grp  : group generate (group produces a carry on its own)
// Every internal carry is a flat sum-of-products of the bit P/G terms and ci,
// so no carry depends on another computed carry.
// -----------------------------------------------------------------------------
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             p_grp,
    output logic             g_grp
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Carry into bit idx: c0 propagated through bits 0..idx-1, OR any bit j
    // below idx that generates and is propagated through bits j+1..idx-1.
    function automatic logic lookahead(input logic [GROUP-1:0] pp,
                                       input logic [GROUP-1:0] gg,
                                       input logic             c0,
                                       input int               idx);
        logic res;
        logic term;
        res = c0;
        for (int j = 0; j < idx; j++) begin
            res = res & pp[j];
        end
        for (int j = 0; j < idx; j++) begin
            term = gg[j];
            for (int k = j + 1; k < idx; k++) begin
                term = term & pp[k];
            end
            res = res | term;
        end
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi <= GROUP; gi++) begin : g_carry
            assign c[gi] = lookahead(p, g, ci, gi);
        end
    endgenerate

    assign s     = p ^ c[GROUP-1:0];
    assign co    = c[GROUP];
    assign p_grp = &p;
    assign g_grp = lookahead(p, g, 1'b0, GROUP);

endmodule

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
// WIDTH-bit adder split into NSTAGE = WIDTH/GROUP lookahead groups, one group
// resolved per pipeline stage; the group carry-out is registered between
// stages. Valid/ready on both sides with a single global advance enable.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipelined_cla_adder_if.slave (operands in, sum out)
// Optional build macro CLA_OVERFLOW_FLAG_EN adds bus.ovf, the signed overflow
// flag (carry into MSB xor cout), registered alongside S.
//
// Stage gi register contents:
//   s_reg  : sum bits of groups 0..gi (lower groups pass down aligned)
//   c_reg  : carry out of group gi
//   v_reg  : stage valid (bubbles travel like data)
//   a_reg/b_reg : operand bits of groups gi+1.. still waiting to be used
// -----------------------------------------------------------------------------
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic clk,
    input  logic rst,
    pipelined_cla_adder_if.slave bus
);

    localparam int NSTAGE = calc_nstage(WIDTH, GROUP);

    generate
        if (!params_ok(WIDTH, GROUP)) begin : g_bad_params
            $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
        end
    endgenerate

    // Whole pipeline moves together whenever the output slot is free or being
    // drained; otherwise every stage holds.
    logic en;
    assign en          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = en & ~rst;

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
            localparam int OPW = WIDTH - gi * GROUP;   // operand bits still pending
            localparam int SW  = (gi + 1) * GROUP;     // sum bits resolved so far

            logic [OPW-1:0]   op_a;
            logic [OPW-1:0]   op_b;
            logic             c_in;
            logic             v_in;
            logic [GROUP-1:0] grp_s;
            logic             grp_co;
            // Group P/G are reserved for a future second-level lookahead;
            // here groups are chained through the carry registers instead.
            logic [1:0]       grp_pg_unused;
            logic [SW-1:0]    s_next;
            logic [SW-1:0]    s_reg;
            logic             c_reg;
            logic             v_reg;

            if (gi == 0) begin : g_first
                assign op_a   = bus.A;
                assign op_b   = bus.B;
                assign c_in   = bus.cin;
                assign v_in   = bus.in_valid;
                assign s_next = grp_s;
            end else begin : g_chain
                assign op_a   = g_stage[gi-1].g_fwd.a_reg;
                assign op_b   = g_stage[gi-1].g_fwd.b_reg;
                assign c_in   = g_stage[gi-1].c_reg;
                assign v_in   = g_stage[gi-1].v_reg;
                assign s_next = {grp_s, g_stage[gi-1].s_reg};
            end

            cla_group #(
                .GROUP (GROUP)
            ) u_group (
                .a     (op_a[GROUP-1:0]),
                .b     (op_b[GROUP-1:0]),
                .ci    (c_in),
                .s     (grp_s),
                .co    (grp_co),
                .p_grp (grp_pg_unused[1]),
                .g_grp (grp_pg_unused[0])
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_reg <= 1'b0;
                    c_reg <= 1'b0;
                    s_reg <= '0;
                end else if (en) begin
                    v_reg <= v_in;
                    c_reg <= grp_co;
                    s_reg <= s_next;
                end
            end

            // Operand skew: higher groups ride along until their stage.
            if (gi < NSTAGE - 1) begin : g_fwd
                logic [OPW-GROUP-1:0] a_reg;
                logic [OPW-GROUP-1:0] b_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (en) begin
                        a_reg <= op_a[OPW-1:GROUP];
                        b_reg <= op_b[OPW-1:GROUP];
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid = g_stage[NSTAGE-1].v_reg;
    assign bus.S         = g_stage[NSTAGE-1].s_reg;
    assign bus.cout      = g_stage[NSTAGE-1].c_reg;

`ifdef CLA_OVERFLOW_FLAG_EN
    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
    logic msb_carry;
    logic ovf_reg;

    assign msb_carry = g_stage[NSTAGE-1].grp_s[GROUP-1]
                     ^ g_stage[NSTAGE-1].op_a[GROUP-1]
                     ^ g_stage[NSTAGE-1].op_b[GROUP-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (en) begin
            ovf_reg <= msb_carry ^ g_stage[NSTAGE-1].grp_co;
        end
    end

    assign bus.ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
// Directed and randomized stimulus for pipelined_cla_adder; results are
// checked against an arithmetic reference (A+B+cin, signed range test for ovf)
// held in an in-order scoreboard queue.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;
    import cla_pkg::*;

    localparam int WIDTH  = 16;
    localparam int GROUP  = 4;
    localparam int NSTAGE = calc_nstage(WIDTH, GROUP);

    typedef struct {
        logic [WIDTH:0] sum;      // {cout, S}
        logic           ovf;
        int             acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cla_adder #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_out = 0;
    bit   check_lat = 1'b0;

    function automatic exp_t model(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic             c,
                                   input int               cy);
        exp_t   e;
        longint sa, sbv, ss, lim;
        e.sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        sa        = longint'($signed(a));
        sbv       = longint'($signed(b));
        ss        = sa + sbv + longint'(c);
        lim       = longint'(1) <<< (WIDTH - 1);
        e.ovf     = (ss >= lim) || (ss < -lim);
        e.acc_cyc = cy;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes just before the edge, update the model,
    // then return at the following falling edge.
    task automatic tick(output bit acc);
        bit   con;
        exp_t e;
        #1;
        acc = bus.in_valid && bus.in_ready;
        con = bus.out_valid && bus.out_ready;
        if (con) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                n_out++;
                $display("out %0d: S=%h cout=%b (cycle %0d)", n_out, bus.S, bus.cout, cyc);
                check("sum", 64'({bus.cout, bus.S}), 64'(e.sum));
`ifdef CLA_OVERFLOW_FLAG_EN
                check("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
                if (check_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(NSTAGE));
            end
        end
        if (acc) sb.push_back(model(bus.A, bus.B, bus.cin, cyc));
        @(posedge clk);
        if (rst) sb.delete();
        cyc++;
        @(negedge clk);
    endtask

    task automatic new_ops();
        bus.A   = WIDTH'($urandom);
        bus.B   = WIDTH'($urandom);
        bus.cin = 1'($urandom);
    endtask

    logic [15:0] str_a [3];
    logic [15:0] str_b [3];
    logic        str_c [3];

    initial begin
        bit acc;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Reset behaviour
        #1 check("in_ready_during_rst", 64'(bus.in_ready), 64'd0);
        tick(acc);
        tick(acc);
        rst = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_S", 64'(bus.S), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
`ifdef CLA_OVERFLOW_FLAG_EN
        check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif

        // All-ones + 1: carry crosses every stage
        check_lat    = 1'b1;
        bus.A        = '1;
        bus.B        = WIDTH'(1);
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        tick(acc);
        check("t1_accepted", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
        repeat (NSTAGE + 2) tick(acc);
        check("t1_drained", 64'(sb.size()), 64'd0);

        // Back-to-back stream, one result per cycle
        str_a[0] = 16'h1234; str_b[0] = 16'h1111; str_c[0] = 1'b0;
        str_a[1] = 16'h8000; str_b[1] = 16'h8000; str_c[1] = 1'b0;
        str_a[2] = 16'h00FF; str_b[2] = 16'h0000; str_c[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.A        = WIDTH'(str_a[i]);
            bus.B        = WIDTH'(str_b[i]);
            bus.cin      = str_c[i];
            bus.in_valid = 1'b1;
            tick(acc);
        end
        bus.in_valid = 1'b0;
        repeat (NSTAGE + 2) tick(acc);
        check("stream_drained", 64'(sb.size()), 64'd0);
        check_lat = 1'b0;

        // Backpressure with the pipeline full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        new_ops();
        repeat (NSTAGE + 4) begin
            tick(acc);
            if (acc) new_ops();
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_sum", 64'({bus.cout, bus.S}), 64'(sb[0].sum));
            tick(acc);
        end
        check("bp_inflight", 64'(sb.size()), 64'(NSTAGE));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (NSTAGE + 3) tick(acc);
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with results in flight
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            new_ops();
            tick(acc);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < NSTAGE + 2; i++) begin
            tick(acc);
            check("midrst_no_stale", 64'(bus.out_valid), 64'd0);
        end

`ifdef CLA_OVERFLOW_FLAG_EN
        // Signed overflow corner cases
        bus.in_valid = 1'b1;
        bus.A = WIDTH'(16'h7FFF); bus.B = WIDTH'(16'h0001); bus.cin = 1'b0;
        tick(acc);
        bus.A = WIDTH'(16'hFFFF); bus.B = WIDTH'(16'h0001); bus.cin = 1'b0;
        tick(acc);
        bus.in_valid = 1'b0;
        repeat (NSTAGE + 2) tick(acc);
        check("ovf_drained", 64'(sb.size()), 64'd0);
`endif

        // Random traffic with random valid/ready; held operands while stalled
        new_ops();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (!(bus.in_valid && !acc)) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                new_ops();
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (NSTAGE + 3) tick(acc);
        check("rand_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
